// File: rtl/mux2to1_arb.sv
// mux2to1_arb: round-robin arbiter driving the select line of a 2-to-1 mux.
//
// Two requesters compete for the shared mux output. One channel at a time
// holds a grant for a tenure of HOLD cycles. s_o is driven so the mux passes
// the granted channel (0 -> w0, 1 -> w1). Ties alternate: the channel that
// was not served last wins. Channel 0 wins the first tie after reset.
//
// Parameters:
//   HOLD     tenure length in cycles, 1..255
//   CW       tenure counter width, 2**CW > HOLD
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req0_i   channel 0 request (level, held until served)
//   req1_i   channel 1 request
//   lock_i   extends the current tenure (only with MUX_ARB_LOCK_EN)
//   s_o      registered mux select
//   gnt0_o   registered channel 0 grant
//   gnt1_o   registered channel 1 grant
//   busy_o   gnt0_o | gnt1_o
//
// Optional feature: define MUX_ARB_LOCK_EN to add lock_i. While lock_i and the
// granted request are high, expiry at cnt == 0 is suppressed. Without it the
// tenure is strictly bounded by HOLD.

module mux2to1_arb #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned CW   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
`ifdef MUX_ARB_LOCK_EN
  input  logic lock_i,
`endif
  output logic s_o,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic busy_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StG0   = 2'd1,
    StG1   = 2'd2
  } state_e;

  localparam logic [CW-1:0] CntLoad = CW'(HOLD - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          s_q, s_d;

  logic lock_hold;
  logic granted_req;
  logic decide;
  logic pick_valid;
  logic pick_ch;

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = lock_i;
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    s_d         = s_q;
    pick_valid  = 1'b0;
    pick_ch     = 1'b0;
    granted_req = (state_q == StG1) ? req1_i : req0_i;

    // Decide in IDLE, on early release, or on expiry (unless locked).
    decide = (state_q == StIdle) || !granted_req || ((cnt_q == '0) && !lock_hold);

    // Priority: lone requester wins; on a tie the channel not served last wins.
    if (req0_i && req1_i) begin
      pick_valid = 1'b1;
      pick_ch    = ~last_q;
    end else if (req0_i) begin
      pick_valid = 1'b1;
      pick_ch    = 1'b0;
    end else if (req1_i) begin
      pick_valid = 1'b1;
      pick_ch    = 1'b1;
    end

    if (decide) begin
      if (pick_valid) begin
        state_d = pick_ch ? StG1 : StG0;
        cnt_d   = CntLoad;
        last_d  = pick_ch;
        s_d     = pick_ch;
      end else begin
        state_d = StIdle;
      end
    end else if (cnt_q != '0) begin
      // Locked at zero: counter holds rather than wrapping.
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      s_q     <= s_d;
    end
  end

  assign s_o    = s_q;
  assign gnt0_o = (state_q == StG0);
  assign gnt1_o = (state_q == StG1);
  assign busy_o = gnt0_o | gnt1_o;

endmodule

// File: tb/tb_mux2to1_arb.sv
// Self-checking bench for mux2to1_arb. Two instances (HOLD=4 and HOLD=1)
// share the request inputs; a per-instance tenure model predicts outputs.
module tb_mux2to1_arb;

  logic clk;
  logic rst_n;
  logic req0, req1, lock;
  logic s4, g04, g14, b4;
  logic s1, g01, g11, b1;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux2to1_arb #(.HOLD(4), .CW(8)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0_i (req0),
    .req1_i (req1),
`ifdef MUX_ARB_LOCK_EN
    .lock_i (lock),
`endif
    .s_o    (s4),
    .gnt0_o (g04),
    .gnt1_o (g14),
    .busy_o (b4)
  );

  mux2to1_arb #(.HOLD(1), .CW(8)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0_i (req0),
    .req1_i (req1),
`ifdef MUX_ARB_LOCK_EN
    .lock_i (lock),
`endif
    .s_o    (s1),
    .gnt0_o (g01),
    .gnt1_o (g11),
    .busy_o (b1)
  );

  // Model: owner (-1 none), cycles left in tenure, last served, select.
  int   own [2];
  int   rem [2];
  int   lst [2];
  logic sel [2];
  int   holdv [2];
  initial begin
    holdv[0] = 4;
    holdv[1] = 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        own[i] = -1;
        rem[i] = 0;
        lst[i] = 1;
        sel[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit r [2];
        bit lk;
        bit pick;
        int c;
        r[0] = req0;
        r[1] = req1;
`ifdef MUX_ARB_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        pick = (own[i] < 0);
        if (!pick) begin
          if (!r[own[i]]) pick = 1'b1;
          else if (rem[i] == 1 && !lk) pick = 1'b1;
          else if (rem[i] > 1) rem[i] = rem[i] - 1;
        end
        if (pick) begin
          if (r[0] && r[1]) c = 1 - lst[i];
          else if (r[0]) c = 0;
          else if (r[1]) c = 1;
          else c = -1;
          own[i] = c;
          if (c >= 0) begin
            rem[i] = holdv[i];
            lst[i] = c;
            sel[i] = c[0];
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Continuous model compare, away from the active edge.
  always @(negedge clk) begin
    check("m4_gnt0", g04, own[0] == 0);
    check("m4_gnt1", g14, own[0] == 1);
    check("m4_busy", b4, own[0] >= 0);
    check("m4_s", s4, sel[0]);
    check("m1_gnt0", g01, own[1] == 0);
    check("m1_gnt1", g11, own[1] == 1);
    check("m1_s", s1, sel[1]);
    check("m_excl", g04 & g14, 1'b0);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_s", s4, 1'b0);
    check("rst_gnt0", g04, 1'b0);
    check("rst_gnt1", g14, 1'b0);
    check("rst_busy", b4, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    lock  = 1'b0;

    // Contention from reset: ch0 1..4, ch1 5..8, ch0 9..12; HOLD=1 alternates.
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      #1;
      check("cont_gnt0", g04, (c <= 4) || (c >= 9));
      check("cont_gnt1", g14, (c >= 5) && (c <= 8));
      check("cont_s", s4, (c >= 5) && (c <= 8));
      check("h1_gnt0", g01, c[0]);
      check("h1_gnt1", g11, !c[0]);
    end

    // Reset asserted mid-cycle while ch1 is granted: outputs clear at once.
    for (int c = 13; c <= 14; c++) @(negedge clk);
    #1;
    check("pre_rst_gnt1", g14, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt1", g14, 1'b0);
    check("async_s", s4, 1'b0);
    check("async_busy", b4, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;

    // Single requester: continuous grant with re-grant and no gap.
    @(negedge clk);
    req0 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      #1;
      check("single_gnt0", g04, 1'b1);
      check("single_s", s4, 1'b0);
    end
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Early release of ch1 after two grant cycles; s stays 1.
    req1 = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      #1;
      check("early_gnt1", g14, 1'b1);
    end
    req1 = 1'b0;
    @(negedge clk);
    #1;
    check("early_drop", g14, 1'b0);
    check("early_busy", b4, 1'b0);
    check("early_s", s4, 1'b1);

`ifdef MUX_ARB_LOCK_EN
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    lock = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
      check("lock_gnt0", g04, 1'b1);
    end
    lock = 1'b0;
    @(negedge clk);
    #1;
    check("lock_handoff", g14, 1'b1);
`endif

    // Randomized traffic with occasional resets, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      lock = ($urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
